digital_dsm: RTL and testbench
==============================

// Module: digital_dsm
// PURPOSE
//  - First-order digital delta-sigma modulator (MASH-1 accumulator) for the fractional-N PLL divider path.
//  - Accumulates the fractional control word alpha every clock and emits the accumulator carry as a 1-bit stream.
//  - Long-run density of MSB = alpha / 2^WIDTH. The stream drives the divider modulus select (N / N+1).
// PARAMETERS
//  - WIDTH  16  accumulator and alpha width in bits; legal range 2..32
// PORTS (declaration order: alpha, MSB, clk, rst_n, acc_out; positional instantiation relies on it)
//  - clk      in   1      rising-edge clock (reference/divider clock)
//  - rst_n    in   1      reset, asynchronous, active-low
//  - alpha    in   WIDTH  unsigned fractional control word; sampled every rising clk edge
//  - MSB      out  1      registered carry-out of the accumulator (modulator bit stream)
//  - acc_out  out  WIDTH  registered accumulator residue (quantisation error), for debug/MASH cascading
// BEHAVIOUR
//  - Reset: rst_n low asynchronously clears acc_out = 0 and MSB = 0. Clears the dither LFSR to seed 16'hACE1 when dither is enabled.
//  - Release: the first accumulation occurs on the first rising clk edge with rst_n high.
//  - Each rising clk edge with rst_n high:
//    - {carry, sum} = acc_out + alpha (+ d, see CONFIGURATION), computed at WIDTH+1 bits.
//    - acc_out <= sum[WIDTH-1:0]
//    - MSB <= carry
//  - Latency: MSB and acc_out update on the same edge that samples alpha. No combinational path from alpha to any output.
//  - Arithmetic: unsigned, modulo 2^WIDTH wrap-around. The overflow bit is the output and is never saturated.
//  - alpha = 0: MSB stays 0 and acc_out holds its value.
//  - alpha = 2^WIDTH-1: the first edge after reset gives MSB = 0; every later edge gives MSB = 1.
//  - alpha change mid-stream: the new value is used from the next edge. acc_out is not cleared.
//  - Reset mid-operation: outputs clear immediately regardless of clk. The residue is discarded.
//  - No enable, no handshake: the block runs every cycle.
// CONFIGURATION
//  - Macro DSM_DITHER_EN.
//  - When defined:
//    - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) advances every clock.
//    - Its bit 0 is added as the carry-in d of the accumulator sum. This breaks idle tones.
//    - Mean MSB density rises by about 2^-(WIDTH+1).
//  - When undefined: d = 0, no LFSR is built, and the output is fully deterministic as specified above.
// TESTING (WIDTH=16, 10 ns clock, DSM_DITHER_EN undefined unless stated)
//  - Reset check:
//    - Hold rst_n=0 and toggle alpha -> MSB=0, acc_out=0.
//    - Assert rst_n mid-stream between edges -> outputs clear at once.
//  - alpha=16'hCCCD after reset release:
//    - MSB over edges 1..6 = 0,1,1,1,1,0.
//    - acc_out = CCCD, 999A, 6667, 3334, 0001, CCCE.
//  - Density check:
//    - alpha=16'h4000 for 4096 cycles -> exactly 1024 MSB ones; pattern period 4 (0,0,0,1).
//  - Boundary values:
//    - alpha=0 -> MSB never 1.
//    - alpha=16'hFFFF -> MSB=0 on edge 1, then 1 on every edge.
//  - Mid-stream change:
//    - Switch alpha 16'h8000 -> 16'h2000 with acc_out=16'h8000 -> next edge MSB=0, acc_out=16'hA000.
//  - Dither (DSM_DITHER_EN):
//    - alpha=0 for 65535 cycles -> MSB density about 2^-17 (nonzero).
//    - LFSR never reaches 0.
//    - Reset reloads 16'hACE1.

Source files
------------

// File: rtl/digital_dsm.sv
// -----------------------------------------------------------------------------
// digital_dsm
//
// First-order digital delta-sigma modulator (MASH-1 accumulator) for the
// fractional-N PLL divider path. The fractional control word alpha is added
// to the accumulator residue on every rising clock edge. The carry out of
// that addition is the 1-bit modulator stream that selects the divider
// modulus (N / N+1). Over the long run, the density of ones on MSB is
// alpha / 2^WIDTH.
//
// Parameters
//   WIDTH    accumulator and alpha width in bits (legal range 2..32)
//
// Ports (declaration order is fixed because positional instantiation
// depends on it)
//   alpha    in   WIDTH  unsigned fractional control word, sampled every edge
//   MSB      out  1      registered accumulator carry (modulator bit stream)
//   clk      in   1      rising-edge clock (reference/divider clock)
//   rst_n    in   1      asynchronous active-low reset
//   acc_out  out  WIDTH  registered accumulator residue (quantisation error)
//
// Optional feature: define DSM_DITHER_EN to build a 16-bit Fibonacci LFSR
// (taps 16,14,13,11, seed 16'hACE1). Its bit 0 is injected as the carry-in
// of the accumulator sum, which breaks up idle tones. When the macro is
// undefined, no LFSR is built and the carry-in is 0.
//
// Both outputs come straight from flops. There is no combinational path
// from alpha to any output.
// -----------------------------------------------------------------------------
module digital_dsm #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] alpha,
   output logic             MSB,
   input  logic             clk,
   input  logic             rst_n,
   output logic [WIDTH-1:0] acc_out
);

   logic             dither_bit;
   logic [WIDTH:0]   sum_next;
   logic [WIDTH-1:0] acc_reg;
   logic [WIDTH-1:0] acc_next;
   logic             msb_reg;
   logic             msb_next;

`ifdef DSM_DITHER_EN
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   logic [15:0] lfsr_reg;
   logic [15:0] lfsr_next;
   logic        lfsr_fb;

   // Fibonacci feedback for x^16 + x^14 + x^13 + x^11 + 1.
   // Taps 16,14,13,11 map to bits 15,13,12,10.
   assign lfsr_fb      = lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10];
   assign lfsr_next[0] = lfsr_fb;

   genvar gi;
   generate
      for (gi = 1; gi < 16; gi++) begin : g_lfsr_shift
         assign lfsr_next[gi] = lfsr_reg[gi-1];
      end
   endgenerate

   // The register starts from a non-zero seed and the feedback is maximal
   // length, so it never enters the all-zero lock-up state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_reg <= LFSR_SEED;
      end else begin
         lfsr_reg <= lfsr_next;
      end
   end

   assign dither_bit = lfsr_reg[0];
`else
   assign dither_bit = 1'b0;
`endif

   // The sum is computed one bit wider than the accumulator.
   // The extra top bit is the carry, and the carry is the modulator output.
   // It is never saturated.
   always_comb begin
      sum_next = {1'b0, acc_reg} + {1'b0, alpha} + {{WIDTH{1'b0}}, dither_bit};
      acc_next = sum_next[WIDTH-1:0];
      msb_next = sum_next[WIDTH];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg <= '0;
         msb_reg <= 1'b0;
      end else begin
         acc_reg <= acc_next;
         msb_reg <= msb_next;
      end
   end

   assign acc_out = acc_reg;
   assign MSB     = msb_reg;

endmodule

// File: tb/tb_digital_dsm.sv
// -----------------------------------------------------------------------------
// tb_digital_dsm
//
// Directed testbench for digital_dsm (WIDTH=16, 10 ns clock, dither off).
// Inputs change 1 ns after a rising edge. Outputs are sampled at that same
// point, so each sample reflects the edge that has just occurred.
// -----------------------------------------------------------------------------
module tb_digital_dsm;

   localparam int WIDTH = 16;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] alpha;
   logic             MSB;
   logic [WIDTH-1:0] acc_out;

   int checks;
   int failures;

   digital_dsm #(.WIDTH(WIDTH)) dut (
      .alpha   (alpha),
      .MSB     (MSB),
      .clk     (clk),
      .rst_n   (rst_n),
      .acc_out (acc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to 1 ns past the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Hold reset across two edges, then release 1 ns after an edge.
   // The next edge is therefore the first accumulation.
   task automatic do_reset();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   logic [15:0] cccd_acc [6];
   logic        cccd_msb [6];

   initial begin
      int ones;
      int pat_err;
      logic [15:0] exp_acc;

      checks   = 0;
      failures = 0;
      rst_n    = 1'b0;
      alpha    = 16'h0000;

      // Reset: hold rst_n low while toggling alpha. The outputs must stay clear.
      tick();
      alpha = 16'hFFFF;
      tick();
      alpha = 16'h5A5A;
      tick();
      check("reset_msb", {31'b0, MSB}, 32'd0);
      check("reset_acc", {16'b0, acc_out}, 32'd0);

      // alpha = CCCD: hand-computed stream for edges 1..6.
      cccd_acc = '{16'hCCCD, 16'h999A, 16'h6667, 16'h3334, 16'h0001, 16'hCCCE};
      cccd_msb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
      alpha = 16'hCCCD;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("cccd_msb_e%0d", i + 1), {31'b0, MSB}, {31'b0, cccd_msb[i]});
         check($sformatf("cccd_acc_e%0d", i + 1), {16'b0, acc_out}, {16'b0, cccd_acc[i]});
      end

      // Asynchronous reset between edges: the outputs must clear before the next edge.
      // acc_out is CCCE here, so a missing clear is visible.
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_acc", {16'b0, acc_out}, 32'd0);
      check("async_rst_msb", {31'b0, MSB}, 32'd0);
      tick();

      // alpha = FFFF: edge 1 gives MSB=0 and acc=FFFF.
      // Every later edge gives MSB=1, and after k edges acc = 2^16 - k.
      alpha = 16'hFFFF;
      rst_n = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check($sformatf("ffff_msb_e%0d", k), {31'b0, MSB}, (k == 1) ? 32'd0 : 32'd1);
         check($sformatf("ffff_acc_e%0d", k), {16'b0, acc_out}, 32'h10000 - k);
      end

      // alpha = 0 straight after reset: MSB stays 0 and acc stays 0.
      alpha = 16'h0000;
      do_reset();
      for (int k = 1; k <= 4; k++) begin
         tick();
         check($sformatf("zero_msb_e%0d", k), {31'b0, MSB}, 32'd0);
         check($sformatf("zero_acc_e%0d", k), {16'b0, acc_out}, 32'd0);
      end

      // alpha = 0 with a nonzero residue: the residue is held.
      alpha = 16'h1234;
      tick();
      check("hold_load_acc", {16'b0, acc_out}, 32'h1234);
      alpha = 16'h0000;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check($sformatf("hold_msb_e%0d", k), {31'b0, MSB}, 32'd0);
         check($sformatf("hold_acc_e%0d", k), {16'b0, acc_out}, 32'h1234);
      end

      // Mid-stream change from 8000 to 2000 with acc=8000.
      // The next edge must give MSB=0 and acc=A000, with no clear of the residue.
      alpha = 16'h8000;
      do_reset();
      tick();
      check("chg_pre_acc", {16'b0, acc_out}, 32'h8000);
      check("chg_pre_msb", {31'b0, MSB}, 32'd0);
      alpha = 16'h2000;
      tick();
      check("chg_msb", {31'b0, MSB}, 32'd0);
      check("chg_acc", {16'b0, acc_out}, 32'hA000);
      tick();
      check("chg2_acc", {16'b0, acc_out}, 32'hC000);

      // Density: alpha = 4000 for 4096 edges must give exactly 1024 ones,
      // in the pattern 0,0,0,1 (a carry on every 4th edge).
      alpha = 16'h4000;
      do_reset();
      ones    = 0;
      pat_err = 0;
      exp_acc = 16'h0000;
      for (int k = 1; k <= 4096; k++) begin
         tick();
         exp_acc = exp_acc + 16'h4000;
         if (MSB)
            ones++;
         if ((MSB !== ((k % 4) == 0)) || (acc_out !== exp_acc))
            pat_err++;
      end
      check("density_ones", ones, 32'd1024);
      check("density_pattern_errors", pat_err, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog: the directed sequence takes about 4200 cycles.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
